// File: rtl/mips_pkg.sv
// mips_pkg: shared op encodings, mul/div sequencer states and sign helpers
package mips_pkg;
  localparam int DATA_W = 32;
  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;
  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_e;
  function automatic logic [DATA_W-1:0] abs_w(input logic [DATA_W-1:0] x, input logic sgn);
    return (sgn && x[DATA_W-1]) ? -x : x;
  endfunction
  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] x, input logic n);
    return n ? -x : x;
  endfunction
  function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] x, input logic n);
    return n ? -x : x;
  endfunction
endpackage

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO
//   CLK, RST (sync, active-low); start/op/opA/opB launch an operation;
//   mthi/mtlo/wdata write HI/LO when idle; flush aborts an operation;
//   busy stalls the pipeline; done/div0 pulse on completion; hi_out/lo_out read HI/LO.
module muldiv_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic              div0,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);
  import mips_pkg::*;
  localparam int CW = $clog2(DATA_W);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d, prod;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, rem_sub;
  logic [DATA_W:0] rem_sh;
  logic div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, done_q, done_d, div0_q, div0_d;
  logic dz, sgn, go, qbit;
  assign dz = start & op[1] & (opB == '0);
  assign sgn = ~op[0];
  assign go = (state_q == IDLE) & start & ~dz;
  // Restoring divide: upper half of acc is the partial remainder, lower half collects quotient bits.
  assign rem_sh = {acc_q[2*DATA_W-1:DATA_W], a_q[cnt_q]};
  assign qbit = rem_sh >= {1'b0, b_q};
  assign rem_sub = rem_sh[DATA_W-1:0] - b_q;
  assign prod = neg_2w(acc_q, neg_q);
  assign done = done_q;
  assign div0 = div0_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;
  always_ff @(posedge CLK) begin
    if (!RST) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = go ? CALC : IDLE;
    else if (flush) state_d = IDLE;
    else if (state_q == CALC) state_d = (cnt_q == '0) ? SIGN : CALC;
    else state_d = IDLE;
  end
  always_comb begin
    busy = (state_q != IDLE) | go;
    a_d = a_q;
    b_d = b_q;
    div_d = div_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    div0_d = 1'b0;
    if (state_q == IDLE) begin
      if (go) begin
        a_d = abs_w(opA, sgn);
        b_d = abs_w(opB, sgn);
        div_d = op[1];
        neg_d = sgn & (opA[DATA_W-1] ^ opB[DATA_W-1]);
        rneg_d = sgn & opA[DATA_W-1];
        acc_d = '0;
        cnt_d = '1;
      end else if (dz) begin
        hi_d = opA;
        lo_d = '1;
        done_d = 1'b1;
        div0_d = 1'b1;
      end else begin
        hi_d = mthi ? wdata : hi_q;
        lo_d = mtlo ? wdata : lo_q;
      end
    end else if (!flush) begin
      if (state_q == CALC) begin
        cnt_d = cnt_q - 1'b1;
        // Both algorithms walk the dividend/multiplier MSB first, indexed by the counter.
        acc_d = div_q ? {qbit ? rem_sub : rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], qbit}
                      : {acc_q[2*DATA_W-2:0], 1'b0} + (a_q[cnt_q] ? {{DATA_W{1'b0}}, b_q} : '0);
      end else begin
        hi_d = div_q ? neg_w(acc_q[2*DATA_W-1:DATA_W], rneg_q) : prod[2*DATA_W-1:DATA_W];
        lo_d = div_q ? neg_w(acc_q[DATA_W-1:0], neg_q) : prod[DATA_W-1:0];
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q <= '0;
      acc_q <= '0;
      a_q <= '0;
      b_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      done_q <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      a_q <= a_d;
      b_q <= b_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      div_q <= div_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      done_q <= done_d;
      div0_q <= div0_d;
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: randomized self-checking bench for muldiv_ctrl against a cycle-level behavioural model
module tb_muldiv_ctrl;
  logic CLK = 1'b0, RST = 1'b0, start = 1'b0, mthi = 1'b0, mtlo = 1'b0, flush = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] opA = '0, opB = '0, wdata = '0;
  logic busy, done, div0;
  logic [31:0] hi_out, lo_out;
  int errors = 0, checks = 0;
  logic armed = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_res = '0;
  logic m_done = 1'b0, m_div0 = 1'b0;
  int m_rem = 0;
  muldiv_ctrl dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .opA(opA), .opB(opB),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .flush(flush),
    .busy(busy), .done(done), .div0(div0), .hi_out(hi_out), .lo_out(lo_out)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Architectural result {HI,LO} computed with plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r, p;
    sa = o[0] ? longint'({32'b0, a}) : longint'($signed(a));
    sb = o[0] ? longint'({32'b0, b}) : longint'($signed(b));
    if (!o[1]) begin
      p = sa * sb;
      return p;
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction
  // An accepted operation keeps the unit busy for 33 more cycles; the last of those writes HI/LO.
  always @(posedge CLK) begin
    if (!RST) begin
      m_hi <= '0;
      m_lo <= '0;
      m_rem <= 0;
      m_done <= 1'b0;
      m_div0 <= 1'b0;
      armed <= 1'b1;
    end else begin
      m_done <= 1'b0;
      m_div0 <= 1'b0;
      if (m_rem > 0) begin
        if (flush) m_rem <= 0;
        else begin
          if (m_rem == 1) begin
            m_hi <= m_res[63:32];
            m_lo <= m_res[31:0];
            m_done <= 1'b1;
          end
          m_rem <= m_rem - 1;
        end
      end else if (start) begin
        if (op[1] && opB == 0) begin
          m_hi <= opA;
          m_lo <= '1;
          m_done <= 1'b1;
          m_div0 <= 1'b1;
        end else begin
          m_res <= model(op, opA, opB);
          m_rem <= 33;
        end
      end else begin
        if (mthi) m_hi <= wdata;
        if (mtlo) m_lo <= wdata;
      end
    end
  end
  always @(negedge CLK) begin
    if (armed) begin
      chk("busy", 64'(busy), 64'(m_rem != 0 || (start && !(op[1] && opB == 0))));
      chk("done", 64'(done), 64'(m_done));
      chk("div0", 64'(div0), 64'(m_div0));
      chk("hi_out", 64'(hi_out), 64'(m_hi));
      chk("lo_out", 64'(lo_out), 64'(m_lo));
    end
  end
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  function automatic logic [31:0] pick;
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int dc, output int bc, output logic [31:0] h, output logic [31:0] l,
                       output logic d0);
    start = 1'b1;
    op = o;
    opA = a;
    opB = b;
    dc = -1;
    bc = 0;
    h = '0;
    l = '0;
    d0 = 1'b0;
    for (int c = 0; c < 40 && dc < 0; c++) begin
      @(negedge CLK);
      if (busy) bc++;
      if (done) begin
        dc = c;
        h = hi_out;
        l = lo_out;
        d0 = div0;
      end
      tick();
      start = 1'b0;
      opA = $urandom;
      opB = $urandom;
    end
    if (dc < 0) chk("done_timeout", 64'd0, 64'd1);
  endtask
  initial begin
    int dc, bc, fa;
    logic [31:0] h, l;
    logic d0;
    chk("model_mult", model(2'b00, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
    chk("model_multu", model(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    chk("model_div", model(2'b10, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("model_ovf", model(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    repeat (3) tick();
    RST = 1'b1;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(hi_out), 64'd0);
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, dc, bc, h, l, d0);
    chk("mult_done_cycle", 64'(dc), 64'd34);
    chk("mult_busy_cycles", 64'(bc), 64'd34);
    chk("mult_result", {h, l}, 64'hFFFF_FFFF_FFFF_FFEB);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, bc, h, l, d0);
    chk("multu_result", {h, l}, 64'hFFFF_FFFE_0000_0001);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, dc, bc, h, l, d0);
    chk("div_result", {h, l}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, dc, bc, h, l, d0);
    chk("div_ovf_result", {h, l}, 64'h0000_0000_8000_0000);
    chk("div_ovf_div0", 64'(d0), 64'd0);
    issue(2'b11, 32'd100, 32'd0, dc, bc, h, l, d0);
    chk("dz_done_cycle", 64'(dc), 64'd1);
    chk("dz_busy_cycles", 64'(bc), 64'd0);
    chk("dz_div0", 64'(d0), 64'd1);
    chk("dz_result", {h, l}, 64'h0000_0064_FFFF_FFFF);
    mthi = 1'b1;
    wdata = 32'h1234;
    tick();
    mthi = 1'b0;
    start = 1'b1;
    op = 2'b00;
    opA = 32'd2;
    opB = 32'd3;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge CLK);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hi", 64'(hi_out), 64'h1234);
    chk("flush_done", 64'(done), 64'd0);
    tick();
    start = 1'b1;
    op = 2'b00;
    opA = 32'd9;
    opB = 32'd9;
    tick();
    start = 1'b0;
    repeat (19) tick();
    RST = 1'b0;
    tick();
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hilo", {hi_out, lo_out}, 64'd0);
    tick();
    issue(2'b00, 32'd5, 32'd5, dc, bc, h, l, d0);
    chk("post_rst_lo", 64'(l), 64'd25);
    start = 1'b1;
    op = 2'b11;
    opA = 32'h55;
    opB = 32'd0;
    mthi = 1'b1;
    mtlo = 1'b1;
    wdata = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    mthi = 1'b0;
    mtlo = 1'b0;
    @(negedge CLK);
    chk("start_beats_mt", {hi_out, lo_out}, 64'h0000_0055_FFFF_FFFF);
    tick();
    for (int i = 0; i < 60; i++) begin
      start = 1'b1;
      op = 2'($urandom);
      opA = pick();
      opB = pick();
      tick();
      start = 1'b0;
      fa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 33) : 0;
      for (int c = 1; c < 37; c++) begin
        flush = (c == fa) || ($urandom_range(0, 15) == 0 && c > 34);
        mthi = $urandom_range(0, 7) == 0;
        mtlo = $urandom_range(0, 7) == 0;
        wdata = $urandom;
        opA = $urandom;
        opB = $urandom;
        tick();
      end
      flush = 1'b0;
      mthi = 1'b0;
      mtlo = 1'b0;
    end
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide sequencer for the MIPS pipeline. It sits beside the EX stage ALU. It takes the forwarded EX operands when a MULT/MULTU/DIV/DIVU instruction reaches EX, runs a 32-step shift-add or restoring-divide sequence, and writes the architectural HI/LO registers. While it runs, it drives a stall request so the front of the pipeline holds. It also serves MFHI/MFLO reads and MTHI/MTLO writes.

## Interface
- DATA_W, 32, operand and HI/LO width; only 32 is supported.
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-low reset.
- start  in  1  asserted for one cycle while a mul/div instruction is in EX.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- opA  in  DATA_W  forwarded rs value; the dividend for DIV/DIVU.
- opB  in  DATA_W  forwarded rt value; the divisor for DIV/DIVU.
- mthi, mtlo  in  1  write wdata to HI or to LO.
- wdata  in  DATA_W  data for MTHI/MTLO.
- flush  in  1  abort any operation in flight; HI/LO are not changed.
- busy  out  1  stall request to the hazard logic.
- done  out  1  one-cycle pulse after HI/LO are updated.
- div0  out  1  pulses together with done when the divisor was 0.
- hi_out, lo_out  out  DATA_W  current HI/LO contents.

## Operation
- FSM states: IDLE, CALC, SIGN.
- IDLE:
  - start=1 with a multiply, or with a divide where opB≠0:
    - latch |opA| and |opB| (raw values for unsigned ops).
    - latch the result-sign bits.
    - clear the 64-bit accumulator and set the 5-bit step counter to 31.
    - next state CALC.
  - start=1 with DIV or DIVU and opB=0:
    - next edge: LO←0xFFFFFFFF, HI←opA.
    - done=1 and div0=1 in the following cycle; state stays IDLE.
- CALC: one step per cycle, counter decrements each step.
  - Multiply: shift-add, one multiplier bit per step.
  - Divide: restoring divide, one quotient bit per step.
  - When the counter reaches 0, next state SIGN.
- SIGN:
  - MULT: negate the 64-bit product when the operand signs differ.
  - DIV: negate the quotient when the operand signs differ; the remainder takes the sign of the dividend.
  - Write HI/LO at the end of the cycle, then go to IDLE.
  - -2^31 / -1 gives LO=0x80000000, HI=0 and raises no flag.
- MTHI/MTLO:
  - Honoured only in IDLE with start=0; the write lands at the next edge.
  - If start, mthi and mtlo are all asserted together, start wins and the writes are dropped.
- start while busy is ignored.
- flush in CALC or SIGN: go to IDLE at the next edge. No done pulse; HI/LO unchanged.
- flush in IDLE has no effect.
- RST low: state IDLE, HI=LO=0, all datapath registers cleared. This applies mid-operation too.

## Timing
- Reset values: busy=0, done=0, div0=0, hi_out=0, lo_out=0.
- busy = (state≠IDLE) | (start & state==IDLE & not divide-by-zero).
  - It is combinational, so the pipeline stalls in the same cycle as start.
- Normal mul/div:
  - start in cycle 0, CALC in cycles 1–32, SIGN in cycle 33.
  - busy is high in cycles 0–33.
  - HI/LO are visible in cycle 34, and done=1 in cycle 34.
  - An MFHI issued in cycle 34 reads the new value.
- Divide by zero: busy stays 0; HI/LO are updated and done=div0=1 in cycle 1.
- done and div0 are registered single-cycle pulses.
- hi_out and lo_out are direct register outputs with no read latency.

## Structure
- Shared package mips_pkg holds:
  - the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
  - the state enum (IDLE, CALC, SIGN).
  - DATA_W.
- Single module: the FSM, counter and 64-bit accumulator are inline. No sub-module is needed.
- The abs/negate helpers are functions placed in the package.

## Test plan
- MULT opA=0xFFFFFFFD (-3), opB=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. done in cycle 34; busy high for exactly 34 cycles.
- MULTU opA=opB=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV opA=0xFFFFFFF9 (-7), opB=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. A second DIV opA=0x80000000, opB=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU opA=100, opB=0 → busy never high. HI=0x64, LO=0xFFFFFFFF, done=div0=1 in cycle 1.
- MTHI 0x1234 in IDLE, then MULT 2×3 flushed in CALC at step 10 → state IDLE next cycle, busy=0, HI=0x1234, no done pulse.
- MULT in flight, RST low at cycle 20 → HI=LO=0 and busy=0 next cycle. After reset release, a new MULT 5×5 → LO=25.
